// File: rtl/ro_pair_meter_if.sv
// Measurement request/result bundle between the RO pair meter and its controller.
// The controller drives requests and the RO lines; the meter returns enables and results.
interface ro_pair_meter_if #(
  parameter int N_CH  = 32,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             start;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [WIN_W-1:0] win_len;
  logic [N_CH-1:0]  ro_in;
  logic [N_CH-1:0]  ro_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             a_gt_b;
  logic             overflow;

  modport master (
    output start, sel_a, sel_b, win_len, ro_in,
    input  ro_en, busy, done, cnt_a, cnt_b, a_gt_b, overflow
  );

  modport slave (
    input  start, sel_a, sel_b, win_len, ro_in,
    output ro_en, busy, done, cnt_a, cnt_b, a_gt_b, overflow
  );
endinterface

// File: rtl/ro_pair_meter.sv
// Two-channel ring-oscillator edge meter: enables a selected pair of ROs, counts their
// synchronised rising edges over a clk-cycle window and compares the saturating counts.
module ro_pair_meter #(
  parameter int N_CH        = 32,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ro_pair_meter_if.slave bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PAD_W = 1 << SEL_W;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t           state;
  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  dly_q;
  logic [N_CH-1:0]  rise;
  logic [PAD_W-1:0] rise_pad;
  logic [SEL_W-1:0] sel_a_q;
  logic [SEL_W-1:0] sel_b_q;
  logic [ARM_W-1:0] arm_left;
  logic [WIN_W-1:0] win_left;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic [N_CH-1:0]  ro_en_q;
  logic             done_q;
  logic             ovf_q;
  logic             hit_a;
  logic             hit_b;

  // Selects beyond N_CH land in the zero padding, so they enable nothing and never count.
  function automatic logic [N_CH-1:0] chan_mask(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b);
    logic [PAD_W-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    return m[N_CH-1:0];
  endfunction

  // NOTE: the synchroniser array is reset too, so stale RO history cannot fake an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= bus.ro_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

  always_comb begin
    rise_pad           = '0;
    rise_pad[N_CH-1:0] = rise;
  end

  assign hit_a = rise_pad[sel_a_q];
  assign hit_b = rise_pad[sel_b_q];

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      arm_left <= '0;
      win_left <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      ro_en_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.win_len != '0)) begin
            sel_a_q  <= bus.sel_a;
            sel_b_q  <= bus.sel_b;
            win_left <= bus.win_len - 1'b1;
            arm_left <= ARM_W'(SYNC_STAGES);
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            ovf_q    <= 1'b0;
            ro_en_q  <= chan_mask(bus.sel_a, bus.sel_b);
            state    <= ARM;
          end
        end
        ARM: begin
          if (arm_left == '0) state <= COUNT;
          else                arm_left <= arm_left - 1'b1;
        end
        COUNT: begin
          // Overflow flags an edge that arrived while the counter was already pinned.
          if (hit_a) begin
            if (cnt_a_q == '1) ovf_q <= 1'b1;
            else               cnt_a_q <= cnt_a_q + 1'b1;
          end
          if (hit_b) begin
            if (cnt_b_q == '1) ovf_q <= 1'b1;
            else               cnt_b_q <= cnt_b_q + 1'b1;
          end
          if (win_left == '0) begin
            state   <= DONE;
            ro_en_q <= '0;
            done_q  <= 1'b1;
          end else begin
            win_left <= win_left - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ro_en    = ro_en_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.cnt_a    = cnt_a_q;
  assign bus.cnt_b    = cnt_b_q;
  assign bus.a_gt_b   = (cnt_a_q > cnt_b_q);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ro_pair_meter.sv
// Directed bench for ro_pair_meter: a 16-bit-counter instance for the main cases and a
// 4-bit-counter instance for saturation, fed by clk-synchronous square waves.
module tb_ro_pair_meter;
  localparam int S = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] phase = '0;
  logic [31:0] ro   = '0;
  int n_checks = 0;
  int n_fail   = 0;

  ro_pair_meter_if #(.N_CH(32), .CNT_W(16), .WIN_W(16)) bus ();
  ro_pair_meter_if #(.N_CH(32), .CNT_W(4),  .WIN_W(16)) sbus ();

  ro_pair_meter #(.N_CH(32), .CNT_W(16), .WIN_W(16), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ro_pair_meter #(.N_CH(32), .CNT_W(4), .WIN_W(16), .SYNC_STAGES(S)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  always #5 clk = ~clk;

  // ch0/ch9 period 2, ch3/ch7 period 4, ch5 period 8; always running, even in reset
  always @(negedge clk) begin
    phase = phase + 3'd1;
    ro    = '0;
    ro[0] = phase[0];
    ro[3] = phase[1];
    ro[5] = phase[2];
    ro[7] = phase[1];
    ro[9] = phase[0];
  end

  assign bus.ro_in  = ro;
  assign sbus.ro_in = ro;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(tag, seen, 0);
  endtask

  // One measurement on the main instance; poke>0 re-requests with other settings mid-run.
  task automatic measure(input string tag, input int sa, input int sb, input int wl,
                         input int poke, input int exp_a, input int exp_b,
                         input int exp_gt, input int exp_ov);
    logic [31:0] mask;
    int done_cyc = -1;
    int en_bad   = 0;
    mask     = '0;
    mask[sa] = 1'b1;
    mask[sb] = 1'b1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sel_a   = 5'(sa);
    bus.sel_b   = 5'(sb);
    bus.win_len = 16'(wl);
    for (int cyc = 1; cyc <= wl + S + 20; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == poke);
      if (cyc == poke) begin
        bus.sel_a   = 5'd0;
        bus.sel_b   = 5'd9;
        bus.win_len = 16'd3;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.ro_en !== mask || bus.busy !== 1'b1) en_bad++;
    end
    check({tag, " done_cycle"}, done_cyc, wl + S + 2);
    check({tag, " ro_en_window_errs"}, en_bad, 0);
    check({tag, " ro_en_at_done"}, bus.ro_en, 0);
    check({tag, " cnt_a"}, bus.cnt_a, exp_a);
    check({tag, " cnt_b"}, bus.cnt_b, exp_b);
    check({tag, " a_gt_b"}, bus.a_gt_b, exp_gt);
    check({tag, " overflow"}, bus.overflow, exp_ov);
    @(negedge clk);
    check({tag, " busy_after"}, bus.busy, 0);
    check({tag, " done_after"}, bus.done, 0);
    check({tag, " cnt_a_held"}, bus.cnt_a, exp_a);
  endtask

  initial begin
    int done_cyc;
    bus.start    = 1'b0;
    bus.sel_a    = '0;
    bus.sel_b    = '0;
    bus.win_len  = '0;
    sbus.start   = 1'b0;
    sbus.sel_a   = '0;
    sbus.sel_b   = '0;
    sbus.win_len = '0;

    // Reset with RO lines toggling
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst ro_en", bus.ro_en, 0);
    check("rst cnt_a", bus.cnt_a, 0);
    check("rst cnt_b", bus.cnt_b, 0);
    check("rst a_gt_b", bus.a_gt_b, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst sat busy", sbus.busy, 0);
    rst_n = 1'b1;

    measure("meas", 3, 5, 64, 0, 16, 8, 1, 0);

    // Start during a running window is neither honoured nor queued
    measure("poke", 3, 5, 64, 10, 16, 8, 1, 0);
    expect_no_done("poke extra_done", 80);

    // Zero-length window request is dropped
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sel_a   = 5'd3;
    bus.sel_b   = 5'd5;
    bus.win_len = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("zero_win busy", bus.busy, 0);
    check("zero_win cnt_a_held", bus.cnt_a, 16);
    expect_no_done("zero_win done", 10);

    // Reset asserted in the middle of COUNT
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sel_a   = 5'd3;
    bus.sel_b   = 5'd5;
    bus.win_len = 16'd64;
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", bus.busy, 0);
    check("midrst ro_en", bus.ro_en, 0);
    check("midrst cnt_a", bus.cnt_a, 0);
    check("midrst cnt_b", bus.cnt_b, 0);
    check("midrst done", bus.done, 0);
    rst_n = 1'b1;
    expect_no_done("midrst no_done", 80);
    measure("post_rst", 3, 5, 64, 0, 16, 8, 1, 0);

    measure("swap", 5, 3, 64, 0, 8, 16, 0, 0);
    measure("same", 7, 7, 32, 0, 8, 8, 0, 0);

    // Reset after a completed measurement clears held results
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2 cnt_a", bus.cnt_a, 0);
    check("rst2 cnt_b", bus.cnt_b, 0);
    rst_n = 1'b1;

    // Saturation on the 4-bit instance: 20 edges on ch0, 5 on ch5
    @(negedge clk);
    sbus.start   = 1'b1;
    sbus.sel_a   = 5'd0;
    sbus.sel_b   = 5'd5;
    sbus.win_len = 16'd40;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      sbus.start = 1'b0;
      if (sbus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("sat done_cycle", done_cyc, 40 + S + 2);
    check("sat cnt_a", sbus.cnt_a, 15);
    check("sat cnt_b", sbus.cnt_b, 5);
    check("sat overflow", sbus.overflow, 1);
    check("sat a_gt_b", sbus.a_gt_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
